// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared types and defaults for the instruction-memory loader
package imem_loader_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int          IMEM_DEPTH    = 512;
    localparam int          IMEM_AW       = 9;
    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0013;

endpackage

// File: rtl/imem_loader_byte_word_packer.sv
// rtl/imem_loader_byte_word_packer.sv - little-endian byte-to-word assembler
//
// Ports:
//   clk, rst           clock, synchronous active-low reset
//   accept_i           a host byte is handshaken this cycle
//   byte_data_i        the handshaken byte
//   byte_last_i        the handshaken byte ends the stream
//   word_valid_o       this handshake completes a word (lane 3)
//   word_o             assembled word, valid with word_valid_o
//   partial_on_last_o  stream ends on lane 0..2
module byte_word_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  byte_data_i,
    input  logic        byte_last_i,
    output logic        word_valid_o,
    output logic [31:0] word_o,
    output logic        partial_on_last_o
);

    logic [1:0] idx_q;
    logic [7:0] lane0_q;
    logic [7:0] lane1_q;
    logic [7:0] lane2_q;

    // Lane 3 is taken straight from the incoming byte so the completed word
    // is available on the 4th handshake itself; the parent registers it.
    assign word_valid_o      = accept_i && (idx_q == 2'd3);
    assign word_o            = {byte_data_i, lane2_q, lane1_q, lane0_q};
    assign partial_on_last_o = accept_i && byte_last_i && (idx_q != 2'd3);

    always_ff @(posedge clk) begin
        if (!rst) begin
            idx_q   <= 2'd0;
            lane0_q <= 8'd0;
            lane1_q <= 8'd0;
            lane2_q <= 8'd0;
        end else if (accept_i) begin
            idx_q <= idx_q + 2'd1;
            case (idx_q)
                2'd0:    lane0_q <= byte_data_i;
                2'd1:    lane1_q <= byte_data_i;
                2'd2:    lane2_q <= byte_data_i;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - NOP-fills instruction memory, then loads it from a host byte stream
//
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   byte_valid/data/last/ready    host byte stream (little-endian words)
//   mem_we/mem_addr/mem_wdata     instruction-memory write port
//   core_hold                     holds the core in reset until loading is done
//   load_done                     sticky completion flag
//   word_count                    stream words written (saturates at DEPTH)
//   err_partial, err_overflow     sticky stream errors
//   checksum                      sum of written stream words when
//                                 IMEM_LOADER_CHECKSUM_EN is defined, else 0
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int          DEPTH    = IMEM_DEPTH,
    parameter int          AW       = IMEM_AW,
    parameter logic [31:0] NOP_WORD = IMEM_NOP_WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          byte_last,
    output logic          byte_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic          core_hold,
    output logic          load_done,
    output logic [AW:0]   word_count,
    output logic          err_partial,
    output logic          err_overflow,
    output logic [31:0]   checksum
);

    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] fill_q, fill_d;
    logic          byte_ready_q, byte_ready_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          core_hold_q, core_hold_d;
    logic          load_done_q, load_done_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic          err_partial_q, err_partial_d;
    logic          err_overflow_q, err_overflow_d;

    logic          accept;
    logic          word_valid;
    logic [31:0]   word;
    logic          partial_on_last;
    logic          stream_we;

    // byte_ready_q is only ever high in LOAD, so it alone qualifies the handshake.
    assign accept = byte_valid && byte_ready_q;

    byte_word_packer u_packer (
        .clk               (clk),
        .rst               (rst),
        .accept_i          (accept),
        .byte_data_i       (byte_data),
        .byte_last_i       (byte_last),
        .word_valid_o      (word_valid),
        .word_o            (word),
        .partial_on_last_o (partial_on_last)
    );

    // A completed word is written only while memory still has room.
    assign stream_we = (state_q == LOAD) && word_valid && (word_count_q != DEPTH_CNT);

    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        mem_we_d       = 1'b0;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        word_count_d   = word_count_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;

        case (state_q)
            FILL: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = fill_q;
                mem_wdata_d = NOP_WORD;
                fill_d      = fill_q + AW'(1);
                if (fill_q == LAST_ADDR) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (stream_we) begin
                    mem_we_d     = 1'b1;
                    mem_addr_d   = word_count_q[AW-1:0];
                    mem_wdata_d  = word;
                    word_count_d = word_count_q + (AW+1)'(1);
                end else if (word_valid) begin
                    err_overflow_d = 1'b1;
                end
                if (accept && byte_last) begin
                    state_d = DONE;
                    if (partial_on_last) begin
                        err_partial_d = 1'b1;
                    end
                end
            end
            DONE: ;
            default: state_d = FILL;
        endcase

        // Keyed off state_q so ready rises only after the last NOP write is
        // presented, and the core is released only after the final stream write.
        byte_ready_d = (state_q == LOAD) && (state_d == LOAD);
        core_hold_d  = (state_q != DONE);
        load_done_d  = (state_q == DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= FILL;
            fill_q         <= '0;
            byte_ready_q   <= 1'b0;
            mem_we_q       <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            core_hold_q    <= 1'b1;
            load_done_q    <= 1'b0;
            word_count_q   <= '0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            fill_q         <= fill_d;
            byte_ready_q   <= byte_ready_d;
            mem_we_q       <= mem_we_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            core_hold_q    <= core_hold_d;
            load_done_q    <= load_done_d;
            word_count_q   <= word_count_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    always_comb begin
        checksum_d = checksum_q;
        if (stream_we) begin
            checksum_d = checksum_q + word;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`else
    assign checksum = '0;
`endif

    assign byte_ready   = byte_ready_q;
    assign mem_we       = mem_we_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign core_hold    = core_hold_q;
    assign load_done    = load_done_q;
    assign word_count   = word_count_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for imem_loader
module tb_imem_loader;

    localparam int          DEPTH = 512;
    localparam int          AW    = 9;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = 8'd0;
    logic          byte_last = 1'b0;
    logic          byte_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_hold;
    logic          load_done;
    logic [AW:0]   word_count;
    logic          err_partial;
    logic          err_overflow;
    logic [31:0]   checksum;

    imem_loader dut (
        .clk          (clk),
        .rst          (rst),
        .byte_valid   (byte_valid),
        .byte_data    (byte_data),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .word_count   (word_count),
        .err_partial  (err_partial),
        .err_overflow (err_overflow),
        .checksum     (checksum)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          wr_count = 0;
    int          hs_bad = 0;
    logic [31:0] shadow [DEPTH];

    always @(negedge clk) begin
        if (mem_we) begin
            shadow[mem_addr] = mem_wdata;
            wr_count++;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        @(negedge clk);
        check("reset_state",
              {byte_ready, mem_we, mem_addr, mem_wdata, core_hold, load_done,
               word_count, err_partial, err_overflow, checksum},
              {1'b0, 1'b0, 9'd0, 32'd0, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0, 32'd0});
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'd0;
        wr_count = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic do_fill();
        int bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            if (!(mem_we === 1'b1 && mem_addr === AW'(i) && mem_wdata === NOP &&
                  byte_ready === 1'b0 && core_hold === 1'b1)) bad++;
        end
        check("fill_sequence", bad, 0);
        @(negedge clk);
        check("ready_after_fill", {byte_ready, mem_we, core_hold, load_done}, 4'b1010);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic last);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = last;
        if (byte_ready !== 1'b1) hs_bad++;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic last);
        for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], last && (b == 3));
    endtask

    typedef struct {
        int          n;
        logic [63:0] bytes;
        int          writes;
        logic        part;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    vec_t        vecs [4];
    logic [31:0] exp_cs;
    int          nop_bad;

    initial begin
        vecs[0] = '{4, 64'h0000_0000_0050_0513, 1, 1'b0, 32'h0050_0513, NOP};
        vecs[1] = '{8, 64'h0020_0113_0010_0093, 2, 1'b0, 32'h0010_0093, 32'h0020_0113};
        vecs[2] = '{6, 64'h0000_0113_0010_0093, 1, 1'b1, 32'h0010_0093, NOP};
        vecs[3] = '{8, 64'hFFFF_FFFF_0000_0001, 2, 1'b0, 32'h0000_0001, 32'hFFFF_FFFF};

        for (int v = 0; v < 4; v++) begin
            do_reset();
            do_fill();
            hs_bad = 0;
            for (int i = 0; i < vecs[v].n; i++) begin
                if (i == vecs[v].n - 1) begin
                    byte_valid = 1'b1;
                    byte_data  = vecs[v].bytes[8*i +: 8];
                    byte_last  = 1'b1;
                    if (byte_ready !== 1'b1) hs_bad++;
                    @(negedge clk);
                    byte_valid = 1'b0;
                    byte_last  = 1'b0;
                end else begin
                    send_byte(vecs[v].bytes[8*i +: 8], 1'b0);
                end
            end
            check($sformatf("v%0d_handshake", v), hs_bad, 0);
            check($sformatf("v%0d_last_cycle", v), {mem_we, core_hold, load_done},
                  {(vecs[v].n % 4 == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0});
            @(negedge clk);
            check($sformatf("v%0d_release", v), {mem_we, core_hold, load_done, byte_ready},
                  4'b0010);
            repeat (2) @(negedge clk);
            check($sformatf("v%0d_word_count", v), word_count, vecs[v].writes);
            check($sformatf("v%0d_errors", v), {err_partial, err_overflow}, {vecs[v].part, 1'b0});
            check($sformatf("v%0d_write_count", v), wr_count, DEPTH + vecs[v].writes);
            check($sformatf("v%0d_mem0", v), shadow[0], vecs[v].w0);
            check($sformatf("v%0d_mem1", v), shadow[1], vecs[v].w1);
            nop_bad = 0;
            for (int a = 2; a < DEPTH; a++) if (shadow[a] !== NOP) nop_bad++;
            check($sformatf("v%0d_nop_rest", v), nop_bad, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
            exp_cs = vecs[v].w0 + ((vecs[v].writes == 2) ? vecs[v].w1 : 32'd0);
`else
            exp_cs = 32'd0;
`endif
            check($sformatf("v%0d_checksum", v), checksum, exp_cs);
        end

        // Overflow: 512 words fill memory, the 513th is dropped.
        do_reset();
        do_fill();
        hs_bad = 0;
        for (int w = 0; w < DEPTH; w++) send_word(32'h1000_0000 + w, 1'b0);
        check("ovf_full_count", {word_count, err_overflow}, {10'd512, 1'b0});
        send_word(32'hDEAD_BEEF, 1'b1);
        repeat (3) @(negedge clk);
        check("ovf_handshake", hs_bad, 0);
        check("ovf_flags", {err_overflow, err_partial, load_done, core_hold}, 4'b1010);
        check("ovf_word_count", word_count, 10'd512);
        check("ovf_write_count", wr_count, 2 * DEPTH);
        check("ovf_mem_first", shadow[0], 32'h1000_0000);
        check("ovf_mem_last", shadow[DEPTH-1], 32'h1000_0000 + DEPTH - 1);

        // Reset mid-LOAD with a half-assembled word pending.
        do_reset();
        do_fill();
        byte_last = 1'b1;
        repeat (3) @(negedge clk);
        byte_last = 1'b0;
        check("idle_last_ignored", {load_done, byte_ready, core_hold}, 3'b011);
        send_word(32'h8765_4321, 1'b0);
        send_byte(8'h77, 1'b0);
        do_reset();
        do_fill();
        hs_bad = 0;
        send_word(32'hDDCC_BBAA, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_handshake", hs_bad, 0);
        check("rst_realigned_word", shadow[0], 32'hDDCC_BBAA);
        check("rst_word_count", word_count, 10'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("rst_checksum", checksum, 32'hDDCC_BBAA);
`else
        check("rst_checksum", checksum, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
